// File: rtl/adc_in_frame.sv
// ADC gain/saturate stage packing samples into tlast-delimited AXI-S frames; adc_valid -> o_tvalid 3 cycles.
// Backpressure is absorbed by a FWFT FIFO; the ADC is never stalled, so samples are dropped (sticky flag) when full.
module adc_in_frame #(
   parameter int FRAME_LEN  = 1024,
   parameter int FIFO_DEPTH = 16,
   parameter int FRAC_BITS  = 30
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] i_mode,
   input  logic [31:0] i_in_zoom,
   input  logic [15:0] i_adc_data,
   input  logic        i_adc_valid,
   input  logic        i_clr_ovf,
   output logic [15:0] o_tdata,
   output logic        o_tvalid,
   input  logic        i_tready,
   output logic        o_tlast,
   output logic        o_overflow,
   output logic        o_sat,
   output logic [15:0] o_frame_cnt
);

   localparam int IW = $clog2(FRAME_LEN);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;
   localparam logic [IW-1:0] IDX_LAST = IW'(FRAME_LEN - 1);
   localparam logic signed [47:0] SAT_MAX = 48'sd32767;
   localparam logic signed [47:0] SAT_MIN = -48'sd32768;

   logic [0:0]          state_q, state_d;
   logic [7:0]          mode_q, mode_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic                s1_vld_q, s1_vld_d;
   logic [15:0]         s1_raw_q, s1_raw_d;
   logic signed [47:0]  s1_prod_q, s1_prod_d;
   logic                s2_vld_q, s2_vld_d;
   logic [15:0]         s2_dat_q, s2_dat_d;
   logic                s2_last_q, s2_last_d;
   logic [AW:0]         wr_ptr_q, wr_ptr_d;
   logic [AW:0]         rd_ptr_q, rd_ptr_d;
   logic                ovf_q, ovf_d;
   logic                sat_q, sat_d;
   logic [15:0]         frame_cnt_q, frame_cnt_d;
   logic [16:0]         mem_q [FIFO_DEPTH];

   logic [7:0]          mode_in;
   logic                mode_in_ok;
   logic                unused_mode_hi;
   logic                s2_load;
   logic                at_last;
   logic signed [47:0]  scaled;
   logic                clip_hi, clip_lo, clip;
   logic [15:0]         scaled_sat;
   logic                empty, full, pop, push, drop;
   logic [16:0]         rd_entry;

   assign mode_in        = i_mode[7:0];
   assign mode_in_ok     = (mode_in == 8'd1) || (mode_in == 8'd2);
   assign unused_mode_hi = |i_mode[31:8];

   assign s2_load = s1_vld_q && (state_q == ST_RUN);
   assign at_last = (idx_q == IDX_LAST);

   // Arithmetic shift of a signed product floors toward -inf.
   assign scaled     = s1_prod_q >>> FRAC_BITS;
   assign clip_hi    = scaled > SAT_MAX;
   assign clip_lo    = scaled < SAT_MIN;
   assign scaled_sat = clip_hi ? 16'h7FFF : (clip_lo ? 16'h8000 : scaled[15:0]);
   assign clip       = s2_load && (mode_q == 8'd2) && (clip_hi || clip_lo);

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop   = !empty && i_tready;
   assign push  = s2_vld_q && (!full || pop);
   assign drop  = s2_vld_q && full && !pop;

   // Mode is only re-sampled at the frame boundary so a frame is never split across modes.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE: begin
            if (mode_in_ok) begin
               state_d = ST_RUN;
               mode_d  = mode_in;
               idx_d   = '0;
            end
         end
         ST_RUN: begin
            if (s2_load) begin
               idx_d = idx_q + IW'(1);
               if (at_last) begin
                  if (mode_in_ok) mode_d = mode_in;
                  else            state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      s1_vld_d    = i_adc_valid && (state_q == ST_RUN);
      s1_raw_d    = i_adc_data;
      s1_prod_d   = $signed({{32{i_adc_data[15]}}, i_adc_data}) *
                    $signed({{16{i_in_zoom[31]}}, i_in_zoom});
      s2_vld_d    = s2_load;
      s2_dat_d    = (mode_q == 8'd2) ? scaled_sat : s1_raw_q;
      s2_last_d   = at_last;
      wr_ptr_d    = wr_ptr_q + (AW+1)'(push);
      rd_ptr_d    = rd_ptr_q + (AW+1)'(pop);
      ovf_d       = drop || (ovf_q && !i_clr_ovf);
      sat_d       = clip || (sat_q && !i_clr_ovf);
      frame_cnt_d = frame_cnt_q + 16'(push && s2_last_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         mode_q      <= '0;
         idx_q       <= '0;
         s1_vld_q    <= 1'b0;
         s1_raw_q    <= '0;
         s1_prod_q   <= '0;
         s2_vld_q    <= 1'b0;
         s2_dat_q    <= '0;
         s2_last_q   <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         ovf_q       <= 1'b0;
         sat_q       <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         idx_q       <= idx_d;
         s1_vld_q    <= s1_vld_d;
         s1_raw_q    <= s1_raw_d;
         s1_prod_q   <= s1_prod_d;
         s2_vld_q    <= s2_vld_d;
         s2_dat_q    <= s2_dat_d;
         s2_last_q   <= s2_last_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         ovf_q       <= ovf_d;
         sat_q       <= sat_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= {s2_last_q, s2_dat_q};
   end

   assign rd_entry    = mem_q[rd_ptr_q[AW-1:0]];
   assign o_tvalid    = !empty;
   assign o_tdata     = empty ? 16'h0000 : rd_entry[15:0];
   assign o_tlast     = !empty && rd_entry[16];
   assign o_overflow  = ovf_q;
   assign o_sat       = sat_q;
   assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_adc_in_frame.sv
// Directed bench for adc_in_frame with FRAME_LEN=16, FIFO_DEPTH=16.
module tb_adc_in_frame;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] i_mode = '0;
   logic [31:0] i_in_zoom = '0;
   logic [15:0] i_adc_data = '0;
   logic        i_adc_valid = 1'b0;
   logic        i_clr_ovf = 1'b0;
   logic        i_tready = 1'b0;
   logic [15:0] o_tdata;
   logic        o_tvalid;
   logic        o_tlast;
   logic        o_overflow;
   logic        o_sat;
   logic [15:0] o_frame_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] q_dat[$];
   logic        q_last[$];

   adc_in_frame #(.FRAME_LEN(16), .FIFO_DEPTH(16), .FRAC_BITS(30)) dut (
      .clk(clk), .rst(rst), .i_mode(i_mode), .i_in_zoom(i_in_zoom),
      .i_adc_data(i_adc_data), .i_adc_valid(i_adc_valid), .i_clr_ovf(i_clr_ovf),
      .o_tdata(o_tdata), .o_tvalid(o_tvalid), .i_tready(i_tready), .o_tlast(o_tlast),
      .o_overflow(o_overflow), .o_sat(o_sat), .o_frame_cnt(o_frame_cnt)
   );

   always #5 clk = ~clk;

   // Record every accepted beat away from the active edge.
   always @(negedge clk) begin
      if (!rst && o_tvalid && i_tready) begin
         q_dat.push_back(o_tdata);
         q_last.push_back(o_tlast);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [16:0] ent(input int i);
      if (i < q_dat.size()) return {q_last[i], q_dat[i]};
      return 17'h1DEAD;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic feed(input logic [15:0] v);
      i_adc_data  = v;
      i_adc_valid = 1'b1;
      tick();
      i_adc_valid = 1'b0;
   endtask

   task automatic do_reset();
      i_mode      = '0;
      i_adc_valid = 1'b0;
      i_clr_ovf   = 1'b0;
      rst         = 1'b1;
      idle(2);
      rst         = 1'b0;
      q_dat.delete();
      q_last.delete();
   endtask

   task automatic start(input logic [31:0] m);
      i_mode = m;
      tick();
   endtask

   initial begin
      int first;
      int cyc;
      logic [16:0] e;

      // Reset state
      do_reset();
      check("rst_tvalid", 32'(o_tvalid), 32'd0);
      check("rst_tdata", 32'(o_tdata), 32'd0);
      check("rst_tlast", 32'(o_tlast), 32'd0);
      check("rst_ovf", 32'(o_overflow), 32'd0);
      check("rst_sat", 32'(o_sat), 32'd0);
      check("rst_fcnt", 32'(o_frame_cnt), 32'd0);

      // Raw ramp over two frames
      i_tready = 1'b1;
      start(32'd1);
      first = -1;
      cyc   = 0;
      for (int i = 0; i < 32; i++) begin
         i_adc_data  = 16'(i);
         i_adc_valid = 1'b1;
         tick();
         cyc++;
         if (o_tvalid && first < 0) first = cyc;
      end
      i_adc_valid = 1'b0;
      idle(6);
      check("t1_first_tvalid", 32'(first), 32'd3);
      check("t1_count", 32'(q_dat.size()), 32'd32);
      for (int i = 0; i < 32; i++) begin
         e = {(i % 16 == 15), 16'(i)};
         check($sformatf("t1_ent%0d", i), 32'(ent(i)), 32'(e));
      end
      check("t1_fcnt", 32'(o_frame_cnt), 32'd2);

      // Scaled by 0.5, floor on negatives
      do_reset();
      i_in_zoom = 32'h2000_0000;
      start(32'd2);
      feed(16'd1000);
      feed(16'hFC17);
      feed(16'hFFFF);
      idle(6);
      check("t2_count", 32'(q_dat.size()), 32'd3);
      check("t2_pos", 32'(ent(0)), 32'h0_01F4);
      check("t2_neg", 32'(ent(1)), 32'h0_FE0B);
      check("t2_m1", 32'(ent(2)), 32'h0_FFFF);
      check("t2_sat", 32'(o_sat), 32'd0);

      // Saturation with ~2.0 gain
      q_dat.delete();
      q_last.delete();
      i_in_zoom = 32'h7FFF_FFFF;
      feed(16'h4E20);
      feed(16'hB1E0);
      idle(5);
      check("t3_hi", 32'(ent(0)), 32'h0_7FFF);
      check("t3_lo", 32'(ent(1)), 32'h0_8000);
      check("t3_sat", 32'(o_sat), 32'd1);
      i_clr_ovf = 1'b1;
      tick();
      i_clr_ovf = 1'b0;
      check("t3_sat_clr", 32'(o_sat), 32'd0);
      feed(16'h4E20);
      i_clr_ovf = 1'b1;
      tick();
      i_clr_ovf = 1'b0;
      check("t3_sat_set_wins", 32'(o_sat), 32'd1);

      // Overflow with tready low
      do_reset();
      start(32'd1);
      i_tready = 1'b0;
      for (int i = 0; i < 20; i++) feed(16'(100 + i));
      idle(4);
      check("t4_ovf", 32'(o_overflow), 32'd1);
      check("t4_fcnt", 32'(o_frame_cnt), 32'd1);
      check("t4_tvalid", 32'(o_tvalid), 32'd1);
      check("t4_head", 32'(o_tdata), 32'd100);
      i_tready = 1'b1;
      idle(20);
      check("t4_count", 32'(q_dat.size()), 32'd16);
      check("t4_ent0", 32'(ent(0)), 32'h0_0064);
      check("t4_ent14", 32'(ent(14)), 32'h0_0072);
      check("t4_ent15", 32'(ent(15)), 32'h1_0073);
      i_clr_ovf = 1'b1;
      tick();
      i_clr_ovf = 1'b0;
      check("t4_ovf_clr", 32'(o_overflow), 32'd0);

      // Mode changes only take effect at frame boundaries
      do_reset();
      i_in_zoom = 32'h2000_0000;
      start(32'd1);
      for (int i = 0; i < 16; i++) begin
         if (i == 5) i_mode = 32'd2;
         feed(16'd200);
      end
      for (int i = 0; i < 16; i++) begin
         if (i == 5) i_mode = 32'd0;
         feed(16'd200);
      end
      for (int i = 0; i < 8; i++) feed(16'd7);
      idle(6);
      check("t5_count", 32'(q_dat.size()), 32'd32);
      check("t5_ent0", 32'(ent(0)), 32'h0_00C8);
      check("t5_ent15", 32'(ent(15)), 32'h1_00C8);
      check("t5_ent16", 32'(ent(16)), 32'h0_0064);
      check("t5_ent31", 32'(ent(31)), 32'h1_0064);
      check("t5_fcnt", 32'(o_frame_cnt), 32'd2);
      check("t5_idle_tvalid", 32'(o_tvalid), 32'd0);

      // Reset with entries queued mid-frame
      do_reset();
      start(32'd1);
      for (int i = 0; i < 16; i++) feed(16'(i));
      idle(4);
      i_tready = 1'b0;
      for (int i = 0; i < 8; i++) feed(16'(50 + i));
      idle(4);
      check("t6_pre_tvalid", 32'(o_tvalid), 32'd1);
      check("t6_pre_fcnt", 32'(o_frame_cnt), 32'd1);
      rst = 1'b1;
      tick();
      check("t6_tvalid", 32'(o_tvalid), 32'd0);
      check("t6_fcnt", 32'(o_frame_cnt), 32'd0);
      check("t6_ovf", 32'(o_overflow), 32'd0);
      check("t6_sat", 32'(o_sat), 32'd0);
      rst = 1'b0;
      q_dat.delete();
      q_last.delete();
      tick();
      i_tready = 1'b1;
      for (int i = 0; i < 16; i++) feed(16'(300 + i));
      idle(6);
      check("t6_count", 32'(q_dat.size()), 32'd16);
      check("t6_ent0", 32'(ent(0)), 32'h0_012C);
      check("t6_ent15", 32'(ent(15)), 32'h1_013B);
      check("t6_fcnt_after", 32'(o_frame_cnt), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
